serial_tx: RTL and testbench

Parallel-in, serial-out frame transmitter: a WIDTH-bit parallel word is captured on a load request and shifted out on a single line as one start bit, WIDTH data bits LSB first, and one stop bit. It sits downstream of the parallel load registers and turns a register's parallel word into a serial stream. The block's serial frame is what a matching serial receiver on the far end will consume.

---
 rtl/serial_tx_pkg.sv | 21 ++
 rtl/serial_tx_bit_timer.sv | 41 ++++
 rtl/serial_tx.sv | 107 ++++++++++
 tb/tb_serial_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// ============================================================================
// serial_tx_pkg : shared FSM state type and default sizing for serial_tx
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_WIDTH        = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

`default_nettype wire

// File: rtl/serial_tx_bit_timer.sv
// ============================================================================
// bit_timer : baud counter, tick high on the last clock of every serial bit
// Revision 1.0
// ============================================================================
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// serial_tx : parallel-in, serial-out frame transmitter (start, LSB-first data, stop)
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PI,
    input  logic             cen,
    output logic             SO,
    output logic             busy,
    output logic             done
);

    localparam int            BW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] C_LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bitcnt_q;
    logic             so_q;
    logic             busy_q;
    logic             done_q;

    logic             w_load;
    logic             w_tick;
    logic [WIDTH-1:0] w_shift;

    // Restarting the timer on the load edge aligns bit boundaries to the frame.
    assign w_load  = (state_q == IDLE) && cen;
    assign w_shift = shreg_q >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_load),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            so_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cen) begin
                        shreg_q  <= PI;
                        bitcnt_q <= '0;
                        so_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        so_q    <= shreg_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (bitcnt_q == C_LAST_BIT) begin
                            so_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shreg_q  <= w_shift;
                            bitcnt_q <= bitcnt_q + BW'(1);
                            so_q     <= w_shift[0];
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SO   = so_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
// tb_serial_tx : directed checks of serial_tx at CLKS_PER_BIT=4 and =1
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] PI;
    logic       cen;
    logic       SO, busy, done;
    logic [3:0] PI1;
    logic       cen1;
    logic       so1, busy1, done1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .PI   (PI),
        .cen  (cen),
        .SO   (SO),
        .busy (busy),
        .done (done)
    );

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .PI   (PI1),
        .cen  (cen1),
        .SO   (so1),
        .busy (busy1),
        .done (done1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [48:0] so_v, busy_v, done_v;
    logic [48:0] exp_two;
    int          odd_cnt;

    initial begin
        rst  = 1'b0;
        cen  = 1'b0;
        PI   = '0;
        cen1 = 1'b0;
        PI1  = '0;
        exp_two = {24'b0000_1111_1111_0000_1111_1111, 1'b1,
                   24'b0000_1111_0000_1111_0000_1111};

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("rst_so",    64'(SO),    64'd1);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_so1",   64'(so1),   64'd1);
        check("rst_busy1", 64'(busy1), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();

        // Single frame, PI=1011
        PI  = 4'b1011;
        cen = 1'b1;
        step();
        cen = 1'b0;
        so_v = '0; busy_v = '0; done_v = '0;
        for (int i = 0; i < 24; i++) begin
            so_v   = {so_v[47:0], SO};
            busy_v = {busy_v[47:0], busy};
            done_v = {done_v[47:0], done};
            step();
        end
        check("single_so",   64'(so_v),   64'h00_0F_F0_FF);
        check("single_busy", 64'(busy_v), 64'hFF_FF_FF);
        check("single_done_early", 64'(done_v), 64'd0);
        check("single_done", 64'(done), 64'd1);
        check("single_busy_end", 64'(busy), 64'd0);
        step();
        check("single_done_pulse", 64'(done), 64'd0);

        // cen held high through a frame, PI changed mid-frame
        PI  = 4'b1011;
        cen = 1'b1;
        step();
        so_v = '0; done_v = '0;
        for (int i = 0; i < 49; i++) begin
            if (i == 10) PI = 4'h5;
            so_v   = {so_v[47:0], SO};
            done_v = {done_v[47:0], done};
            if (i == 25) cen = 1'b0;
            step();
        end
        check("b2b_so",   64'(so_v),   64'(exp_two));
        check("b2b_done", 64'(done_v), 64'(49'h1 << 24));
        check("b2b_done2", 64'(done), 64'd1);
        step();

        // Reset during the second data bit
        PI  = 4'b1011;
        cen = 1'b1;
        step();
        cen = 1'b0;
        repeat (9) step();
        check("mid_busy_pre", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_so",   64'(SO),   64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        #2 rst = 1'b0;
        odd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (SO !== 1'b1 || busy !== 1'b0 || done !== 1'b0) odd_cnt++;
        end
        check("mid_quiet", 64'(odd_cnt), 64'd0);
        PI  = 4'h0;
        cen = 1'b1;
        step();
        cen = 1'b0;
        so_v = '0;
        for (int i = 0; i < 24; i++) begin
            so_v = {so_v[47:0], SO};
            step();
        end
        check("zero_so",   64'(so_v), 64'h00_00_0F);
        check("zero_done", 64'(done), 64'd1);

        // CLKS_PER_BIT=1 instance
        PI1  = 4'hA;
        cen1 = 1'b1;
        step();
        cen1 = 1'b0;
        so_v = '0; done_v = '0;
        for (int i = 0; i < 6; i++) begin
            so_v   = {so_v[47:0], so1};
            done_v = {done_v[47:0], done1};
            step();
        end
        check("cpb1_so",    64'(so_v),   64'b001011);
        check("cpb1_early", 64'(done_v), 64'd0);
        check("cpb1_done",  64'(done1),  64'd1);

        // Idle stability
        odd_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (SO !== 1'b1 || busy !== 1'b0 || done !== 1'b0) odd_cnt++;
        end
        check("idle_stable", 64'(odd_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
